// File: rtl/alu_control_unit_if.sv
// alu_control_unit_if: decode request/response bundle between the ID stage
// and the ALU-control decoder.
//   opcode    : 5-bit instruction major opcode   (master -> slave)
//   funct     : 5-bit instruction function field (master -> slave)
//   operation : 5-bit registered ALU op code     (slave -> master)
//   illegal   : registered undefined-encoding flag (slave -> master)
interface alu_control_unit_if;
  logic [4:0] opcode;
  logic [4:0] funct;
  logic [4:0] operation;
  logic       illegal;

  modport master (output opcode, funct, input  operation, illegal);
  modport slave  (input  opcode, funct, output operation, illegal);
endinterface

// File: rtl/alu_control_unit.sv
// alu_control_unit: registered ALU-operation decoder at the ID/EX boundary.
// Decodes {opcode, funct} into a 5-bit ALU operation plus an illegal flag;
// both outputs come straight from flops, one cycle after sampling.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (operation=0, illegal=0)
//   bus : slave side of alu_control_unit_if (opcode/funct in,
//         operation/illegal out)
module alu_control_unit (
  input  logic                clk,
  input  logic                rst,
  alu_control_unit_if.slave   bus
);

  typedef enum logic [4:0] {
    OPC_NOP = 5'd0, OPC_ART = 5'd1, OPC_LOG = 5'd2, OPC_CRY = 5'd3,
    OPC_IMM = 5'd4, OPC_LD  = 5'd5, OPC_ST  = 5'd6
  } opc_e;

  typedef enum logic [4:0] {
    OP_NOP = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_MUL = 5'd3,
    OP_DIV = 5'd4,  OP_INC = 5'd5,  OP_DEC = 5'd6,  OP_AND = 5'd7,
    OP_OR  = 5'd8,  OP_XOR = 5'd9,  OP_NOT = 5'd10, OP_SHL = 5'd11,
    OP_SHR = 5'd12, OP_ADC = 5'd13, OP_SBB = 5'd14, OP_ROL = 5'd15,
    OP_ROR = 5'd16, OP_PASSB = 5'd17
  } op_e;

  op_e  op_d;
  logic ill_d;

  // Out-of-range funct for a funct-decoded opcode falls through to the
  // default arm of the inner case, giving NOP + illegal.
  always_comb begin
    op_d  = OP_NOP;
    ill_d = 1'b0;
    case (bus.opcode)
      OPC_NOP: ;
      OPC_ART:
        case (bus.funct)
          5'd0: op_d = OP_ADD;
          5'd1: op_d = OP_SUB;
          5'd2: op_d = OP_MUL;
          5'd3: op_d = OP_DIV;
          5'd4: op_d = OP_INC;
          5'd5: op_d = OP_DEC;
          default: ill_d = 1'b1;
        endcase
      OPC_LOG:
        case (bus.funct)
          5'd0: op_d = OP_AND;
          5'd1: op_d = OP_OR;
          5'd2: op_d = OP_XOR;
          5'd3: op_d = OP_NOT;
          5'd4: op_d = OP_SHL;
          5'd5: op_d = OP_SHR;
          default: ill_d = 1'b1;
        endcase
      OPC_CRY:
        case (bus.funct)
          5'd0: op_d = OP_ADC;
          5'd1: op_d = OP_SBB;
          5'd2: op_d = OP_ROL;
          5'd3: op_d = OP_ROR;
          default: ill_d = 1'b1;
        endcase
      OPC_IMM:
        case (bus.funct)
          5'd0: op_d = OP_ADD;
          5'd1: op_d = OP_SUB;
          5'd2: op_d = OP_AND;
          5'd3: op_d = OP_OR;
          5'd4: op_d = OP_XOR;
          5'd5: op_d = OP_PASSB;
          default: ill_d = 1'b1;
        endcase
      // Loads/stores only need the base + offset address add.
      OPC_LD, OPC_ST: op_d = OP_ADD;
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.operation <= 5'd0;
      bus.illegal   <= 1'b0;
    end else begin
      bus.operation <= op_d;
      bus.illegal   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_control_unit.sv
module tb_alu_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  alu_control_unit_if bus ();

  alu_control_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] opc;
    logic [4:0] fn;
    logic [4:0] op;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  // Reference model: per-opcode lookup tables of legal functs.
  int art_tab[6] = '{1, 2, 3, 4, 5, 6};
  int log_tab[6] = '{7, 8, 9, 10, 11, 12};
  int cry_tab[4] = '{13, 14, 15, 16};
  int imm_tab[6] = '{1, 2, 7, 8, 9, 17};

  function automatic void ref_decode(input int opc, input int fn,
                                     output int op, output bit ill);
    op  = 0;
    ill = 1'b0;
    if (opc == 0)                    op = 0;
    else if (opc == 5 || opc == 6)   op = 1;
    else if (opc == 1 && fn < 6)     op = art_tab[fn];
    else if (opc == 2 && fn < 6)     op = log_tab[fn];
    else if (opc == 3 && fn < 4)     op = cry_tab[fn];
    else if (opc == 4 && fn < 6)     op = imm_tab[fn];
    else                             ill = 1'b1;
  endfunction

  task automatic check(input string name, input logic [4:0] exp_op,
                       input logic exp_ill);
    vectors++;
    if (bus.operation !== exp_op || bus.illegal !== exp_ill) begin
      miscompares++;
      $display("FAIL %s: got op=%b ill=%b, expected op=%b ill=%b",
               name, bus.operation, bus.illegal, exp_op, exp_ill);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [4:0] o,
                              input logic [4:0] f, input logic [4:0] e,
                              input logic i);
    vec_t v;
    v.name = n; v.opc = o; v.fn = f; v.op = e; v.ill = i;
    return v;
  endfunction

  initial begin
    logic [4:0] prev_op;
    logic       prev_ill;
    int         rop;
    bit         rill;

    vecs.push_back(mk("art_sub",   5'd1,  5'd1,  5'b00010, 1'b0));
    vecs.push_back(mk("log_xor",   5'd2,  5'd2,  5'b01001, 1'b0));
    vecs.push_back(mk("cry_ror",   5'd3,  5'd3,  5'b10000, 1'b0));
    vecs.push_back(mk("imm_xor",   5'd4,  5'd4,  5'b01001, 1'b0));
    vecs.push_back(mk("imm_passb", 5'd4,  5'd5,  5'b10001, 1'b0));
    vecs.push_back(mk("imm_bad",   5'd4,  5'd6,  5'b00000, 1'b1));
    vecs.push_back(mk("st_add",    5'd6,  5'd5,  5'b00001, 1'b0));
    vecs.push_back(mk("ld_add",    5'd5,  5'd6,  5'b00001, 1'b0));
    vecs.push_back(mk("ld_add_ff", 5'd5,  5'd31, 5'b00001, 1'b0));
    vecs.push_back(mk("undef_op0", 5'd31, 5'd0,  5'b00000, 1'b1));
    vecs.push_back(mk("undef_op1", 5'd31, 5'd17, 5'b00000, 1'b1));
    vecs.push_back(mk("cry_bad",   5'd3,  5'd4,  5'b00000, 1'b1));
    vecs.push_back(mk("art_bad",   5'd1,  5'd31, 5'b00000, 1'b1));
    vecs.push_back(mk("nop_fn7",   5'd0,  5'd7,  5'b00000, 1'b0));
    vecs.push_back(mk("art_dec",   5'd1,  5'd5,  5'b00110, 1'b0));
    vecs.push_back(mk("log_and",   5'd2,  5'd0,  5'b00111, 1'b0));
    vecs.push_back(mk("undef_op7", 5'd7,  5'd0,  5'b00000, 1'b1));

    // Reset held with a live instruction on the bus and clock running.
    bus.opcode = 5'd1;
    bus.funct  = 5'd1;
    #1 check("reset_async", 5'd0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1 check("reset_hold", 5'd0, 1'b0);
    end
    @(negedge clk); rst = 1'b0;
    #1 check("reset_release_pre", 5'd0, 1'b0);
    @(posedge clk); #1 check("reset_first_edge", 5'b00010, 1'b0);

    // Directed table: inputs change at negedge must not show before the
    // next rising edge, then the decode must appear right after it.
    prev_op  = 5'b00010;
    prev_ill = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.opcode = vecs[i].opc;
      bus.funct  = vecs[i].fn;
      #1 check({vecs[i].name, "_hold"}, prev_op, prev_ill);
      @(posedge clk); #1 check(vecs[i].name, vecs[i].op, vecs[i].ill);
      prev_op  = vecs[i].op;
      prev_ill = vecs[i].ill;
    end

    // Randomized back-to-back stream against the table model.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.opcode = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                               : 5'($urandom_range(0, 7));
      bus.funct  = ($urandom_range(0, 1) == 0) ? 5'($urandom)
                                               : 5'($urandom_range(0, 7));
      ref_decode(int'(bus.opcode), int'(bus.funct), rop, rill);
      @(posedge clk); #1 check("random", 5'(rop), rill);
    end

    // Async reset mid-cycle: load ART/0 (ADD), then assert rst between edges.
    @(negedge clk);
    bus.opcode = 5'd1;
    bus.funct  = 5'd0;
    @(posedge clk); #1 check("pre_reset_add", 5'b00001, 1'b0);
    #2 rst = 1'b1;
    #1 check("midcycle_reset", 5'd0, 1'b0);
    @(posedge clk); #1 check("midcycle_reset_hold", 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.opcode = 5'd2;
    bus.funct  = 5'd3;
    @(posedge clk); #1 check("post_reset_not", 5'b01010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
